urna_votos: RTL and testbench

- Ballot-collection stage placed directly upstream of the three-input majority voter.
- Opens a voting round on request and accepts at most one vote per voter.
- Closes the round when all three voters have voted or a timeout expires.
- Presents the registered votes a, b, c with a one-cycle valid strobe to the voter, which combinationally produces the majority.

---
 rtl/urna_votos_pkg.sv | 23 ++
 rtl/urna_votos_if.sv | 18 +
 rtl/urna_defs.vh | 5 +
 rtl/urna_votos_temporizador.sv | 46 ++++
 rtl/urna_votos.sv | 110 +++++++++++
 tb/tb_urna_votos.sv | 194 +++++++++++++++++++
 6 files changed

// File: rtl/urna_votos_pkg.sv
// Types and helpers for the ballot-collection stage feeding the majority voter.
package urna_votos_pkg;
   `include "urna_defs.vh"

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_OPEN = S_OPEN,
      ST_DONE = S_DONE,
      ST_ILL  = 2'b11
   } state_e;

   localparam logic [2:0] ALL_VOTED = 3'b111;

   // Only the first press of each voter in a round counts.
   function automatic logic [2:0] accept_mask(input logic [2:0] press, input logic [2:0] voted);
      return press & ~voted;
   endfunction

   function automatic logic [2:0] merge_votes(input logic [2:0] cur, input logic [2:0] vin,
                                              input logic [2:0] acc);
      return (cur & ~acc) | (vin & acc);
   endfunction
endpackage

// File: rtl/urna_votos_if.sv
// Ballot bus between the voting console (master) and the urn (slave).
interface urna_votos_if;
   logic       start;
   logic [2:0] vin;
   logic [2:0] press;
   logic       a;
   logic       b;
   logic       c;
   logic [2:0] voted;
   logic       busy;
   logic       valid;
   logic [7:0] rounds;

   modport master (output start, vin, press,
                   input  a, b, c, voted, busy, valid, rounds);
   modport slave  (input  start, vin, press,
                   output a, b, c, voted, busy, valid, rounds);
endinterface

// File: rtl/urna_defs.vh
// State encodings and default round length shared by the urna_votos slice.
localparam logic [1:0] S_IDLE = 2'b00;
localparam logic [1:0] S_OPEN = 2'b01;
localparam logic [1:0] S_DONE = 2'b10;
localparam int TIMEOUT_DEF = 100;

// File: rtl/urna_votos_temporizador.sv
// Round timer: cleared while idle, counts while open, flags the last open cycle.
module temporizador
   import urna_votos_pkg::*;
#(
   parameter int TW      = 8,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [TW-1:0] count,
   output logic          end_o
);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] count_d, count_q;
   logic          end_d, end_q;

   // Next count and end flag, the flag tracking the value the counter is about to hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {TW{1'b0}};
      end else if (en) begin
         count_d = count_q + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
      end_d = (count_d == LAST);
   end

   // Counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {TW{1'b0}};
         end_q   <= (LAST == {TW{1'b0}});
      end else begin
         count_q <= count_d;
         end_q   <= end_d;
      end
   end

   assign count = count_q;
   assign end_o = end_q;
endmodule

// File: rtl/urna_votos.sv
// Ballot urn: collects one vote per voter per round and hands a, b, c to the majority voter.
module urna_votos
   import urna_votos_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   urna_votos_if.slave  bus
);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [2:0] vote_q, vote_d;
   logic [2:0] voted_q, voted_d;
   logic       busy_q, busy_d;
   logic       valid_q, valid_d;
   logic [7:0] rounds_q, rounds_d;

   logic          tmr_clr_s;
   logic          tmr_en_s;
   logic          tmr_end_s;
   logic [TW-1:0] tmr_count_s;
   logic          timeout_s;
   logic [2:0]    accept_s;
   logic          all_s;

   temporizador #(
      .TW      (TW),
      .TIMEOUT (TIMEOUT)
   ) u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr_s),
      .en    (tmr_en_s),
      .count (tmr_count_s),
      .end_o (tmr_end_s)
   );

   // Round control: next state, ballot contents, round counter and registered flags.
   always_comb begin
      state_d   = state_q;
      vote_d    = vote_q;
      voted_d   = voted_q;
      rounds_d  = rounds_q;
      tmr_clr_s = (state_q == ST_IDLE);
      tmr_en_s  = (state_q == ST_OPEN);
      accept_s  = accept_mask(bus.press, voted_q);
      all_s     = ((voted_q | bus.press) == ALL_VOTED);
      // A counter found past its last value (upset) also closes the round.
      timeout_s = tmr_end_s | (tmr_count_s > LAST);
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_OPEN;
               vote_d  = 3'b000;
               voted_d = 3'b000;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OPEN: begin
            vote_d  = merge_votes(vote_q, bus.vin, accept_s);
            voted_d = voted_q | accept_s;
            if (all_s || timeout_s) begin
               state_d  = ST_DONE;
               rounds_d = rounds_q + 8'd1;
            end else begin
               state_d = ST_OPEN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d  = (state_d == ST_OPEN);
      valid_d = (state_d == ST_DONE);
   end

   // Round state and all outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         vote_q   <= 3'b000;
         voted_q  <= 3'b000;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         rounds_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         vote_q   <= vote_d;
         voted_q  <= voted_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         rounds_q <= rounds_d;
      end
   end

   assign bus.a      = vote_q[0];
   assign bus.b      = vote_q[1];
   assign bus.c      = vote_q[2];
   assign bus.voted  = voted_q;
   assign bus.busy   = busy_q;
   assign bus.valid  = valid_q;
   assign bus.rounds = rounds_q;
endmodule

// File: tb/tb_urna_votos.sv
// Self-checking bench for urna_votos: directed rounds plus random ballots against a round-level model.
module tb_urna_votos;
   localparam int TO = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [2:0] pt [0:TO+2];
   logic [2:0] vt [0:TO+2];
   logic [7:0] exp_rounds = 8'd0;
   logic [2:0] held_vote  = 3'b000;
   logic [2:0] held_voted = 3'b000;

   urna_votos_if ifc ();

   urna_votos #(.TIMEOUT(TO), .TW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   function automatic logic maj(input logic [2:0] v);
      return ($countones(v) >= 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic st, input logic [2:0] v, input logic [2:0] p);
      @(negedge clk);
      ifc.start = st;
      ifc.vin   = v;
      ifc.press = p;
      @(posedge clk);
      #1;
      chk("busy_valid_excl", 32'(ifc.busy & ifc.valid), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"},   32'(ifc.busy), 32'd0);
      chk({tag, "_valid"},  32'(ifc.valid), 32'd0);
      chk({tag, "_rounds"}, 32'(ifc.rounds), 32'(exp_rounds));
      chk({tag, "_votes"},  32'({ifc.c, ifc.b, ifc.a}), 32'(held_vote));
      chk({tag, "_voted"},  32'(ifc.voted), 32'(held_voted));
   endtask

   task automatic clear_tab();
      for (int j = 0; j <= TO + 2; j++) begin
         pt[j] = 3'b000;
         vt[j] = 3'b000;
      end
   endtask

   task automatic rand_tab();
      for (int j = 0; j <= TO + 2; j++) begin
         for (int i = 0; i < 3; i++) pt[j][i] = ($urandom_range(0, 3) == 0);
         vt[j] = 3'($urandom_range(0, 7));
      end
   endtask

   // One round: the model decides the closing cycle and final ballot from the rules, then the DUT is driven.
   task automatic run_round(input string tag);
      logic [2:0] mv;
      logic [2:0] mvote;
      int         close;
      mv    = 3'b000;
      mvote = 3'b000;
      close = TO;
      for (int j = 1; j <= TO; j++) begin
         for (int i = 0; i < 3; i++) begin
            if (pt[j][i] && !mv[i]) begin
               mv[i]    = 1'b1;
               mvote[i] = vt[j][i];
            end
         end
         if (mv == 3'b111) begin
            close = j;
            break;
         end
      end
      tick(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      chk({tag, "_open_busy"}, 32'(ifc.busy), 32'd1);
      for (int j = 1; j <= close; j++) begin
         tick(1'($urandom_range(0, 1)), vt[j], pt[j]);
         if (j < close) begin
            chk({tag, "_busy"},  32'(ifc.busy), 32'd1);
            chk({tag, "_valid"}, 32'(ifc.valid), 32'd0);
         end
      end
      exp_rounds = exp_rounds + 8'd1;
      held_vote  = mvote;
      held_voted = mv;
      chk({tag, "_done_valid"}, 32'(ifc.valid), 32'd1);
      chk({tag, "_done_busy"},  32'(ifc.busy), 32'd0);
      chk({tag, "_votes"},      32'({ifc.c, ifc.b, ifc.a}), 32'(mvote));
      chk({tag, "_voted"},      32'(ifc.voted), 32'(mv));
      chk({tag, "_rounds"},     32'(ifc.rounds), 32'(exp_rounds));
      chk({tag, "_majority"},   32'(maj({ifc.c, ifc.b, ifc.a})), 32'(maj(mvote)));
      // start during DONE must not reopen the round
      tick(1'b1, 3'b111, 3'b111);
      check_idle({tag, "_after"});
      tick(1'b0, 3'b111, 3'b111);
      check_idle({tag, "_idle"});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ifc.start = 1'b0;
      ifc.vin   = 3'b000;
      ifc.press = 3'b000;
      #12;
      chk("reset_busy",   32'(ifc.busy), 32'd0);
      chk("reset_valid",  32'(ifc.valid), 32'd0);
      chk("reset_rounds", 32'(ifc.rounds), 32'd0);
      chk("reset_votes",  32'({ifc.c, ifc.b, ifc.a}), 32'd0);
      chk("reset_voted",  32'(ifc.voted), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // presses in IDLE are ignored
      tick(1'b0, 3'b111, 3'b111);
      check_idle("idle_press");
      tick(1'b0, 3'b101, 3'b111);
      check_idle("idle_press2");

      clear_tab();
      pt[1] = 3'b111; vt[1] = 3'b101;
      run_round("full");

      clear_tab();
      pt[2] = 3'b001; vt[2] = 3'b001;
      run_round("timeout");

      clear_tab();
      pt[1] = 3'b010; vt[1] = 3'b010;
      pt[2] = 3'b010; vt[2] = 3'b000;
      pt[3] = 3'b101; vt[3] = 3'b100;
      run_round("double");
      chk("double_b_kept", 32'(ifc.b), 32'd1);

      // reset in the middle of an open round
      tick(1'b1, 3'b000, 3'b000);
      chk("mid_busy", 32'(ifc.busy), 32'd1);
      tick(1'b0, 3'b011, 3'b011);
      chk("mid_voted", 32'(ifc.voted), 32'd3);
      chk("mid_votes", 32'({ifc.c, ifc.b, ifc.a}), 32'd3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_busy",   32'(ifc.busy), 32'd0);
      chk("rst_rounds", 32'(ifc.rounds), 32'd0);
      chk("rst_votes",  32'({ifc.c, ifc.b, ifc.a}), 32'd0);
      chk("rst_voted",  32'(ifc.voted), 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      exp_rounds = 8'd0;
      held_vote  = 3'b000;
      held_voted = 3'b000;
      for (int k = 0; k < 8; k++) begin
         tick(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         check_idle("post_rst");
      end

      for (int r = 0; r < 256; r++) begin
         clear_tab();
         pt[1] = 3'b111;
         vt[1] = 3'($urandom_range(0, 7));
         run_round("wrap");
      end
      chk("wrap_zero", 32'(ifc.rounds), 32'd0);

      for (int r = 0; r < 40; r++) begin
         rand_tab();
         run_round("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
